// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file and its read ports.
package regfile_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam int unsigned CNT_W        = 32;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_rdport.sv
// One operand read port: priority mux of reset, enable, r0, write bypass, then array.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS,
    parameter int unsigned NREGS  = REG_NUM
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] regs [NREGS],
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if (rst != RST_ENABLE && re == READ_ENABLE && raddr != '0) begin
            // Same-cycle write is forwarded so ID sees it without a stall
            if (we == WRITE_ENABLE && waddr == raddr) begin
                rdata = wdata;
            end else begin
                rdata = regs[raddr];
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: write-back commit, two bypassed read ports,
// plus a commit counter and per-register written flags for debug.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS,
    parameter int unsigned NREGS  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [CNT_W-1:0]  wr_count,
    output logic [NREGS-1:0]  written
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic [NREGS-1:0]  written_q;
    logic [NREGS-1:0]  written_d;

    // Writes to r0 are dropped entirely, including the commit count
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        written_d  = written_q;
        if (we == WRITE_ENABLE && waddr != '0) begin
            regs_d[waddr]    = wdata;
            written_d[waddr] = 1'b1;
            wr_count_d       = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
            written_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            written_q  <= written_d;
        end
    end

    assign wr_count = wr_count_q;
    assign written  = written_q;

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rdport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs_q),
        .rdata (rdata1)
    );

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rdport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs_q),
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected values, a negedge monitor compares.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] wr_count;
    logic [31:0] written;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          st;
        logic [31:0] cnt;
        logic [31:0] wr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .wr_count (wr_count),
        .written  (written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, fld, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare one entry per negedge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cmp(cur.name, "rdata1", rdata1, cur.r1);
            cmp(cur.name, "rdata2", rdata2, cur.r2);
            if (cur.st) begin
                cmp(cur.name, "wr_count", wr_count, cur.cnt);
                cmp(cur.name, "written", written, cur.wr);
            end
        end
    end

    task automatic drv(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input bit e1, input logic [4:0] a1, input bit e2, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    endtask

    task automatic expect_c(input string n, input logic [31:0] r1, input logic [31:0] r2,
                            input bit st, input logic [31:0] cnt, input logic [31:0] wr);
        exp_t e;
        e.name = n; e.r1 = r1; e.r2 = r2; e.st = st; e.cnt = cnt; e.wr = wr;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        // Reset held with a write presented: nothing commits, reads forced to zero
        drv(0, 1, 5'd5, 32'hAAAA_5555, 1, 5'd5, 1, 5'd5);
        expect_c("rst_hold0", 32'h0, 32'h0, 1, 32'd0, 32'h0);
        drv(0, 1, 5'd5, 32'hAAAA_5555, 1, 5'd5, 1, 5'd5);
        expect_c("rst_hold1", 32'h0, 32'h0, 1, 32'd0, 32'h0);

        // r3 write, bypass in its cycle, then via the array
        drv(1, 1, 5'd3, 32'hDEAD_BEEF, 1, 5'd3, 0, 5'd3);
        expect_c("wr_r3_byp", 32'hDEAD_BEEF, 32'h0, 1, 32'd0, 32'h0);
        drv(1, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd0);
        expect_c("rd_r3", 32'hDEAD_BEEF, 32'h0, 1, 32'd1, 32'h0000_0008);

        // Both ports bypass the same address
        drv(1, 1, 5'd7, 32'h1234_5678, 1, 5'd7, 1, 5'd7);
        expect_c("dual_byp", 32'h1234_5678, 32'h1234_5678, 1, 32'd1, 32'h0000_0008);

        // r0 write discarded, r0 never bypassed
        drv(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd7);
        expect_c("wr_r0", 32'h0, 32'h1234_5678, 1, 32'd2, 32'h0000_0088);
        drv(1, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd3);
        expect_c("rd_r0", 32'h0, 32'hDEAD_BEEF, 1, 32'd2, 32'h0000_0088);

        // Fill r1..r31 with i; port2 reads the previous register from the array
        for (int i = 1; i < 32; i++) begin
            drv(1, 1, 5'(i), 32'(i), 1, 5'(i), 1, 5'(i - 1));
            expect_c("fill", 32'(i), (i == 1) ? 32'h0 : 32'(i - 1), 0, 32'h0, 32'h0);
        end
        drv(1, 0, 5'd0, 32'h0, 1, 5'd31, 1, 5'd17);
        expect_c("fill_done", 32'd31, 32'd17, 1, 32'd33, 32'hFFFF_FFFE);

        // Reset cycle with a write presented; state still visible until the edge
        drv(0, 1, 5'd9, 32'h0000_0099, 1, 5'd31, 1, 5'd9);
        expect_c("mid_rst", 32'h0, 32'h0, 1, 32'd33, 32'hFFFF_FFFE);
        drv(1, 1, 5'd4, 32'h0000_0044, 1, 5'd9, 1, 5'd4);
        expect_c("post_rst", 32'h0, 32'h0000_0044, 1, 32'd0, 32'h0);
        drv(1, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd9);
        expect_c("first_wr", 32'h0000_0044, 32'h0, 1, 32'd1, 32'h0000_0010);

        // Counter wrap: preload the next-count value, then commit one write
        drv(1, 0, 5'd0, 32'h0, 0, 5'd4, 1, 5'd4);
        force dut.wr_count_d = 32'hFFFF_FFFF;
        expect_c("re1_off", 32'h0, 32'h0000_0044, 1, 32'd1, 32'h0000_0010);
        drv(1, 1, 5'd2, 32'h0000_0022, 1, 5'd2, 1, 5'd4);
        release dut.wr_count_d;
        expect_c("preload", 32'h0000_0022, 32'h0000_0044, 1, 32'hFFFF_FFFF, 32'h0000_0010);
        drv(1, 0, 5'd0, 32'h0, 0, 5'd2, 1, 5'd2);
        expect_c("wrap", 32'h0, 32'h0000_0022, 1, 32'd0, 32'h0000_0014);

        // High-bit data stored unmodified
        drv(1, 1, 5'd30, 32'h8000_0001, 0, 5'd0, 0, 5'd0);
        expect_c("wr_hi", 32'h0, 32'h0, 1, 32'd0, 32'h0000_0014);
        drv(1, 0, 5'd0, 32'h0, 1, 5'd30, 1, 5'd31);
        expect_c("rd_hi", 32'h8000_0001, 32'h0, 1, 32'd1, 32'h4000_0014);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
